fp_to_twos_decoder: RTL and testbench
=====================================

FP_TO_TWOS_DECODER -- requirements
Module: fp_to_twos_decoder

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  input word presented.
REQ-004 SHALL have port: in_ready  output  1  block can accept an input word.
REQ-005 SHALL have port: in_sign  input  1  sign bit (1 = negative).
REQ-006 SHALL have port: in_exp  input  3  exponent, 0..7.
REQ-007 SHALL have port: in_sig  input  4  significand, unsigned, 0..15.
REQ-008 SHALL have port: out_valid  output  1  out_data holds a result.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port: out_data  output  12  two's-complement result.

Function
REQ-011 SHALL compute the magnitude as in_sig shifted left by in_exp, giving 0..1920; this SHALL always fit in 11 bits.
REQ-012 SHALL drive out_data = magnitude when sign=0 and out_data = (~magnitude)+1 (12-bit) when sign=1.
REQ-013 SHALL drive out_data = 12'h000 for magnitude 0 with either sign; no negative zero.
REQ-014 SHALL implement the states IDLE, SHIFT, SIGN and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; in_ready SHALL be decoded from the state register only.
REQ-016 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, registering sign, exp and sig internally.
REQ-017 SHALL go IDLE->SHIFT on accept when exp!=0 and IDLE->SIGN on accept when exp=0.
REQ-018 In SHIFT, each edge SHALL shift the magnitude left 1 bit and decrement the count; the edge that brings the count to 0 SHALL go to SIGN.
REQ-019 The SIGN edge SHALL load out_data, set out_valid=1 and go to DONE.
REQ-020 Latency from the accept edge to the edge that sets out_valid SHALL be exp+1 cycles (1..8).
REQ-021 In DONE, out_valid and out_data SHALL be held stable until an edge with out_ready=1.
REQ-022 On that edge, out_valid SHALL clear, the state SHALL go to IDLE and out_data SHALL keep its last value.
REQ-023 The block SHALL NOT accept a new word in the same cycle a result is consumed; the minimum input-to-input spacing is exp+3 cycles.
REQ-024 Changes on in_sign, in_exp, in_sig or in_valid outside IDLE SHALL have no effect on the word in progress.
REQ-025 out_ready outside DONE SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, out_data=12'h000, shift count=0 and magnitude=0, with no clock edge needed.
REQ-027 in_ready SHALL read 1 while rst_n=0.
REQ-028 Reset asserted mid-SHIFT, in SIGN or in DONE SHALL discard the word in progress; no result SHALL appear after release.
REQ-029 The first accept after reset release SHALL occur on the first edge with rst_n=1 and in_valid=1.

Configuration
REQ-030 Macro FP_DECODER_BARREL_EN, when defined, SHALL make the accept edge load sig<<exp in one step and go directly IDLE->SIGN, giving a fixed latency of 1 cycle for all exp.
REQ-031 Without FP_DECODER_BARREL_EN, the SHIFT state and the latency of REQ-020 SHALL apply.
REQ-032 Results and handshake SHALL be identical in both builds apart from latency.

Verification
REQ-033 Bench SHALL check: sign=0, exp=3, sig=4'b1011, out_ready=1 -> out_data=12'h058 (88), out_valid 4 cycles after accept, in_ready high the cycle after consume.
REQ-034 Bench SHALL check: sign=1, exp=7, sig=15 -> out_data=12'h880 (-1920), latency 8 (1 with FP_DECODER_BARREL_EN).
REQ-035 Bench SHALL check: sign=1, exp=0, sig=0 -> out_data=12'h000, latency 1; sign=1, exp=0, sig=1 -> 12'hFFF.
REQ-036 Bench SHALL check backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with different data -> out_data held, in_ready=0, new word accepted only after consume.
REQ-037 Bench SHALL check: rst_n pulsed low during the 3rd SHIFT cycle of an exp=6 word -> out_valid stays 0, out_data=12'h000, in_ready=1, next word decodes correctly.

Source files
------------

// File: rtl/fp_to_twos_decoder.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_twos_decoder
// Brief    : Decodes a sign/3-bit-exponent/4-bit-significand word into a
//            12-bit two's-complement integer with a valid/ready handshake.
//            Define FP_DECODER_BARREL_EN to shift in one step (latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module fp_to_twos_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [2:0]  in_exp,
    input  logic [3:0]  in_sig,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [10:0] mag_q, mag_d;
    logic [11:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            cnt_q       <= 3'd0;
            mag_q       <= 11'd0;
            out_data_q  <= 12'h000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
`ifdef FP_DECODER_BARREL_EN
                    mag_d   = {7'd0, in_sig} << in_exp;
                    cnt_d   = 3'd0;
                    state_d = SIGN;
`else
                    mag_d   = {7'd0, in_sig};
                    cnt_d   = in_exp;
                    state_d = (in_exp != 3'd0) ? SHIFT : SIGN;
`endif
                end
            end
            SHIFT: begin
                mag_d = mag_q << 1;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                // Negating a zero magnitude wraps back to zero, so no negative zero.
                out_data_d  = sign_q ? (~{1'b0, mag_q} + 12'd1) : {1'b0, mag_q};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_twos_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_to_twos_decoder
// Brief    : Scoreboard bench for fp_to_twos_decoder with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_to_twos_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [2:0]  in_exp;
    logic [3:0]  in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;

    fp_to_twos_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: value = (-1)^sign * sig * 2^exp, reduced modulo 4096.
    function automatic logic [11:0] model(input bit s, input int e, input int g);
        int          m;
        int          v;
        logic [31:0] vv;
        m  = g * (2 ** e);
        v  = s ? -m : m;
        vv = v;
        return vv[11:0];
    endfunction

    function automatic int lat(input int e);
`ifdef FP_DECODER_BARREL_EN
        return 1;
`else
        return e + 1;
`endif
    endfunction

    // Called shortly after a rising edge; returns shortly after the accept edge.
    task automatic send(input bit s, input int e, input int g,
                        input bit use_want, input logic [11:0] want);
        exp_t x;
        int   t;
        in_sign  = s;
        in_exp   = 3'(e);
        in_sig   = 4'(g);
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready && rst_n) break;
            t++;
            if (t > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: actual no accept required accept within 100 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        x.data = use_want ? want : model(s, e, g);
        x.due  = cycle + 1 + lat(e);
        sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 3'($urandom);
        in_sig   = 4'($urandom);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor
    logic        prev_valid = 1'b0;
    logic [11:0] held       = 12'h000;
    bit          consumed   = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            consumed   = 1'b0;
        end else begin
            if (consumed) begin
                chk("in_ready_after_consume", 32'(in_ready), 32'd1);
                chk("valid_cleared", 32'(out_valid), 32'd0);
                chk("data_kept_after_consume", 32'(out_data), 32'(held));
                consumed = 1'b0;
            end
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual %0h required no result", out_data);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(x.data));
                    chk("latency_cycle", 32'(cycle), 32'(x.due));
                end
                held = out_data;
            end else if (out_valid) begin
                chk("data_hold", 32'(out_data), 32'(held));
            end
            if (out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) consumed = 1'b1;
            prev_valid = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 3'd0;
        in_sig    = 4'd0;
        out_ready = 1'b0;
        #3;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'h000);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;

        send(1'b0, 3, 4'b1011, 1'b1, 12'h058);
        send(1'b1, 7, 15, 1'b1, 12'h880);
        send(1'b1, 0, 0, 1'b1, 12'h000);
        send(1'b1, 0, 1, 1'b1, 12'hFFF);
        send(1'b0, 0, 0, 1'b1, 12'h000);
        send(1'b0, 7, 15, 1'b1, 12'h780);

        // Backpressure: second word waits with in_valid high while first is held.
        repeat (12) @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(1'b0, 2, 5, 1'b1, 12'h014);
                send(1'b1, 1, 9, 1'b1, 12'hFEE);
            end
            begin
                t = 0;
                while (!out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_reached_done", 32'(out_valid), 32'd1);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Reset in the third SHIFT cycle of an exp=6 word.
        repeat (12) @(posedge clk);
        #1;
        send(1'b1, 6, 3, 1'b0, 12'h000);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'h000);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send(1'b0, 6, 3, 1'b1, 12'h0C0);

        // First accept directly after reset release.
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b1, 4, 7, 1'b0, 12'h000);

        // Randomized traffic with random backpressure and gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b0, 12'h000);
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        rand_rdy  = 1'b0;
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
